writeback_unit: RTL
===================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have ports: clk in 1 (sole clock); resetN in 1 (synchronous, active-low reset; sampled on rising clk).
REQ-002 SHALL have ports: resultValidIn in 1, execute result offered; resultReadyOut out 1, result accepted when valid&&ready at clk edge.
REQ-003 SHALL have ports: destRegIn in [0:3], destRegValidIn in 1, destValueIn in [63:0]; primary destination.
REQ-004 SHALL have ports: destRegisterSpecialIn in [0:3], destRegisterSpecialValidIn in 1, destSpecialValueIn in [63:0]; second destination (IMUL RDX).
REQ-005 SHALL have port nextRipIn in [0:63], RIP after the retiring instruction.
REQ-006 SHALL have ports: registerFileOut out [63:0] x16, registered architectural file feeding register read; ripOut out [0:63], committed RIP.
REQ-007 SHALL have ports: wbStallOut out 1, stall to read stage; pendingMaskOut out [15:0], bit n set while any buffered entry targets register n; retiredCountOut out [31:0].

Function
REQ-008 SHALL buffer accepted results in a 2-entry FIFO, entries holding all REQ-003..005 fields.
REQ-009 SHALL drive resultReadyOut = (count < 2), a registered-state function only; no combinational dependence on the pop of the same cycle.
REQ-010 SHALL drive wbStallOut = (count == 2) || (state == WR_SPECIAL).
REQ-011 SHALL run a drain FSM with states IDLE, WR_PRIMARY, WR_SPECIAL; IDLE when count==0.
REQ-012 SHALL, in IDLE or WR_PRIMARY with count>0, process the head entry as follows.
- Primary valid: write destValue to file[destReg].
- Special also valid: go to WR_SPECIAL without popping.
- Otherwise: pop.
REQ-013 SHALL, in WR_SPECIAL, write destSpecialValue to file[destRegisterSpecial], then pop.
REQ-014 SHALL, for a head entry with neither destination valid, pop in one cycle with no file write.
REQ-015 SHALL provide one file write port; at most one register write per cycle.
REQ-016 SHALL make each write visible on registerFileOut the cycle after the write edge.
REQ-017 SHALL, when primary and special name the same register, leave the special value in the file (special written last).
REQ-018 SHALL, on every pop, load ripOut <= head nextRip and increment retiredCountOut by 1; 32-bit wrap 0xFFFFFFFF -> 0.
REQ-019 SHALL, after a pop, continue with the next entry in the following cycle (WR_PRIMARY if count>0 after pop, else IDLE); no bubble.
REQ-020 SHALL handle accept and pop in the same cycle: count unchanged and FIFO order preserved.
REQ-021 SHALL compute pendingMaskOut combinationally from valid FIFO entries, setting both primary and special dest bits.
REQ-022 SHALL ignore destRegisterSpecialValidIn's pairing rule only in that 64-bit values are written whole; no partial-width merging.
REQ-023 SHALL write nothing and leave state unchanged when count==0.

Reset
REQ-024 SHALL, while resetN==0 at a clk edge, apply the following.
- count=0, state=IDLE.
- All 16 registers = 0, ripOut = 0, retiredCountOut = 0.
- resultReadyOut=1 after the edge; wbStallOut=0; pendingMaskOut=0.
REQ-025 SHALL discard buffered entries if reset asserts mid-WR_SPECIAL; no partial commit after reset.
REQ-026 SHALL ignore resultValidIn on any cycle where resetN==0.

Verification
REQ-027 Single result: dest R3, value 0x1122334455667788, rip 0x400010 -> file[3]=0x1122334455667788 and ripOut=0x400010 two edges after accept; retiredCountOut=1.
REQ-028 IMUL pair: primary R0=0x5, special R2=0x7 -> R0 written on cycle 1, R2 on cycle 2; wbStallOut=1 during WR_SPECIAL; one pop.
REQ-029 Back-to-back, valid every cycle, all single-dest, to R1..R4 -> resultReadyOut never drops; one retire per cycle; retiredCountOut=4.
REQ-030 Fill: two IMUL-pair results back-to-back -> count reaches 2; resultReadyOut=0 and wbStallOut=1; pendingMaskOut shows all four dest bits; drains in 4 cycles.
REQ-031 Same register: primary R5=0xAA, special R5=0xBB -> file[5]=0xBB after drain.
REQ-032 Counter preset to 0xFFFFFFFF by forcing, then one retire -> 0; reset asserted in WR_SPECIAL -> all outputs per REQ-024 next cycle.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback unit: buffers execute results in a 2-entry FIFO and retires them
// into a 16 x 64-bit architectural register file through a single write port.
module writeback_unit (
    input  logic        clk,
    input  logic        resetN,
    input  logic        resultValidIn,
    output logic        resultReadyOut,
    input  logic [3:0]  destRegIn,
    input  logic        destRegValidIn,
    input  logic [63:0] destValueIn,
    input  logic [3:0]  destRegisterSpecialIn,
    input  logic        destRegisterSpecialValidIn,
    input  logic [63:0] destSpecialValueIn,
    input  logic [63:0] nextRipIn,
    output logic [63:0] registerFileOut [0:15],
    output logic [63:0] ripOut,
    output logic        wbStallOut,
    output logic [15:0] pendingMaskOut,
    output logic [31:0] retiredCountOut
);

    typedef enum logic [1:0] {
        IDLE,
        WR_PRIMARY,
        WR_SPECIAL
    } state_t;

    typedef struct packed {
        logic [3:0]  dest_reg;
        logic        dest_valid;
        logic [63:0] dest_value;
        logic [3:0]  spec_reg;
        logic        spec_valid;
        logic [63:0] spec_value;
        logic [63:0] next_rip;
    } entry_t;

    state_t      state;
    state_t      next_state;
    logic [1:0]  count;
    logic [1:0]  next_count;
    logic        head;
    logic        tail;
    entry_t      fifo [0:1];
    entry_t      head_entry;

    logic        accept;
    logic        pop;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [63:0] wr_data;

    assign head_entry     = fifo[head];
    assign resultReadyOut = (count != 2'd2);
    assign accept         = resultValidIn && resultReadyOut;
    assign wbStallOut     = (count == 2'd2) || (state == WR_SPECIAL);

    // NOTE: every signal gets a default at the top of the block so that no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        pop        = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        next_state = state;

        if (count != 2'd0) begin
            if (state == WR_SPECIAL) begin
                wr_en   = 1'b1;
                wr_addr = head_entry.spec_reg;
                wr_data = head_entry.spec_value;
                pop     = 1'b1;
            end else begin
                if (head_entry.dest_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = head_entry.dest_reg;
                    wr_data = head_entry.dest_value;
                end
                // The special half goes out next cycle; the entry stays at the head.
                if (head_entry.spec_valid) begin
                    next_state = WR_SPECIAL;
                end else begin
                    pop = 1'b1;
                end
            end
        end

        next_count = count + {1'b0, accept} - {1'b0, pop};

        if (pop) begin
            next_state = (next_count != 2'd0) ? WR_PRIMARY : IDLE;
        end
    end

    always_comb begin
        pendingMaskOut = '0;
        for (int i = 0; i < 2; i++) begin
            if ((count == 2'd2) || ((count == 2'd1) && (head == 1'(i)))) begin
                if (fifo[i].dest_valid) pendingMaskOut[fifo[i].dest_reg] = 1'b1;
                if (fifo[i].spec_valid) pendingMaskOut[fifo[i].spec_reg] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state           <= IDLE;
            count           <= 2'd0;
            head            <= 1'b0;
            tail            <= 1'b0;
            ripOut          <= '0;
            retiredCountOut <= '0;
            for (int i = 0; i < 16; i++) begin
                registerFileOut[i] <= '0;
            end
        end else begin
            state <= next_state;
            count <= next_count;
            if (accept) begin
                tail <= ~tail;
            end
            if (pop) begin
                head            <= ~head;
                ripOut          <= head_entry.next_rip;
                retiredCountOut <= retiredCountOut + 32'd1;
            end
            if (wr_en) begin
                registerFileOut[wr_addr] <= wr_data;
            end
        end
    end

    // NOTE: FIFO payload is deliberately left out of reset; only count and the
    // pointers decide which slots are live, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo[tail] <= '{
                dest_reg:   destRegIn,
                dest_valid: destRegValidIn,
                dest_value: destValueIn,
                spec_reg:   destRegisterSpecialIn,
                spec_valid: destRegisterSpecialValidIn,
                spec_value: destSpecialValueIn,
                next_rip:   nextRipIn
            };
        end
    end

endmodule
